// File: rtl/mc_move_scheduler.sv
// Monte Carlo 2048 move chooser: runs TRIALS playouts per first-move direction on one
// shared engine and reports the direction with the largest summed move count.
// Optional watchdog: define MC_TIMEOUT_EN to add the WAIT timeout and timeout_seen port.
module mc_move_scheduler #(
    parameter int         TRIALS  = 16,
    parameter int         CNT_W   = 15,
    parameter int         SUM_W   = 32,
    parameter logic [2:0] PROB    = 3'd7,
    parameter int         TIMEOUT = 65535
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [79:0]      board_in,
    output logic             busy,
    output logic             done,
    output logic [1:0]       best_dir,
    output logic [SUM_W-1:0] best_score,
    output logic             no_move,
    output logic             eng_rst,
    output logic [79:0]      eng_board,
    output logic [1:0]       eng_dir,
    output logic [2:0]       eng_prob,
    input  logic             eng_done,
    input  logic [CNT_W-1:0] eng_count,
    input  logic             eng_illegal
`ifdef MC_TIMEOUT_EN
    ,output logic            timeout_seen
`endif
);

    localparam int TRIAL_W = (TRIALS > 1) ? $clog2(TRIALS) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_DECIDE,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         dir_q;
    logic [TRIAL_W-1:0] trial_q;
    logic [SUM_W-1:0]   sum_q [4];
    logic [3:0]         invalid_q;
    logic [79:0]        board_q;
    logic [1:0]         best_dir_q;
    logic [SUM_W-1:0]   best_score_q;
    logic               no_move_q;

    logic               accept;
    logic               trial_end;
    logic               trial_illegal;
    logic [CNT_W-1:0]   trial_count;
    logic               last_trial;
    logic               dir_step;
    logic [SUM_W:0]     sum_wide;
    logic [SUM_W-1:0]   sum_sat;
    logic [1:0]         pick_dir;
    logic [SUM_W-1:0]   pick_score;
    logic               pick_found;

`ifdef MC_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);

    logic [TO_W-1:0] wait_cnt_q;
    logic            timeout_hit;
    logic            timeout_seen_q;

    assign timeout_hit = (state_q == S_WAIT) && !eng_done &&
                         (wait_cnt_q == TO_W'(TIMEOUT - 1));

    // A timed-out playout is scored as a legal trial that survived zero moves.
    assign trial_end     = eng_done | timeout_hit;
    assign trial_illegal = eng_done & eng_illegal;
    assign trial_count   = eng_done ? eng_count : '0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            wait_cnt_q     <= '0;
            timeout_seen_q <= 1'b0;
        end else begin
            if (state_q == S_LAUNCH)
                wait_cnt_q <= '0;
            else if (state_q == S_WAIT && !timeout_hit)
                wait_cnt_q <= wait_cnt_q + 1'b1;

            if (accept)
                timeout_seen_q <= 1'b0;
            else if (timeout_hit)
                timeout_seen_q <= 1'b1;
        end
    end

    assign timeout_seen = rst ? timeout_seen_q : 1'b0;
`else
    assign trial_end     = eng_done;
    assign trial_illegal = eng_illegal;
    assign trial_count   = eng_count;
`endif

    assign accept     = (state_q == S_IDLE) && start;
    assign last_trial = (trial_q == TRIAL_W'(TRIALS - 1));
    // An illegal first move makes the remaining trials of that direction pointless.
    assign dir_step   = trial_illegal || last_trial;

    assign sum_wide = {1'b0, sum_q[dir_q]} + {{(SUM_W + 1 - CNT_W){1'b0}}, trial_count};
    assign sum_sat  = sum_wide[SUM_W] ? {SUM_W{1'b1}} : sum_wide[SUM_W-1:0];

    always_ff @(posedge clk) begin
        if (!rst)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_LAUNCH;
            S_LAUNCH: state_d = S_WAIT;
            S_WAIT: begin
                if (trial_end)
                    state_d = (dir_step && dir_q == 2'd3) ? S_DECIDE : S_LAUNCH;
            end
            S_DECIDE: state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Strict greater-than while scanning upward keeps ties on the lowest direction.
    always_comb begin
        pick_dir   = 2'd0;
        pick_score = '0;
        pick_found = 1'b0;
        for (int d = 0; d < 4; d++) begin
            if (!invalid_q[d] && (!pick_found || sum_q[d] > pick_score)) begin
                pick_dir   = 2'(d);
                pick_score = sum_q[d];
                pick_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            dir_q        <= '0;
            trial_q      <= '0;
            invalid_q    <= '0;
            board_q      <= '0;
            best_dir_q   <= '0;
            best_score_q <= '0;
            no_move_q    <= 1'b0;
            for (int d = 0; d < 4; d++)
                sum_q[d] <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        board_q   <= board_in;
                        dir_q     <= '0;
                        trial_q   <= '0;
                        invalid_q <= '0;
                        for (int d = 0; d < 4; d++)
                            sum_q[d] <= '0;
                    end
                end
                S_WAIT: begin
                    if (trial_end) begin
                        if (trial_illegal)
                            invalid_q[dir_q] <= 1'b1;
                        else
                            sum_q[dir_q] <= sum_sat;

                        if (dir_step) begin
                            trial_q <= '0;
                            dir_q   <= dir_q + 2'd1;
                        end else begin
                            trial_q <= trial_q + 1'b1;
                        end
                    end
                end
                S_DECIDE: begin
                    best_dir_q   <= pick_found ? pick_dir : 2'd0;
                    best_score_q <= pick_found ? pick_score : '0;
                    no_move_q    <= !pick_found;
                end
                default: ;
            endcase
        end
    end

    // Outputs are forced to their reset values combinationally so they are clean
    // even before the first clock edge of a reset.
    assign busy       = rst && (state_q == S_LAUNCH || state_q == S_WAIT || state_q == S_DECIDE);
    assign done       = rst && (state_q == S_DONE);
    assign eng_rst    = !rst || (state_q == S_LAUNCH);
    assign eng_board  = rst ? board_q : '0;
    assign eng_dir    = rst ? dir_q : '0;
    assign eng_prob   = rst ? PROB : '0;
    assign best_dir   = rst ? best_dir_q : '0;
    assign best_score = rst ? best_score_q : '0;
    assign no_move    = rst ? no_move_q : 1'b0;

endmodule

// File: tb/tb_mc_move_scheduler.sv
// Directed bench for mc_move_scheduler: a TRIALS=2 / SUM_W=15 instance and a TRIALS=4
// instance share one scripted engine model; only the selected instance is ever started.
module tb_mc_move_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        start2, start4;
    logic [79:0] board_in;
    logic        eng_done;
    logic [14:0] eng_count;
    logic        eng_illegal;

    logic        busy2, done2, no_move2, eng_rst2;
    logic [1:0]  best_dir2, eng_dir2;
    logic [14:0] best_score2;
    logic [79:0] eng_board2;
    logic [2:0]  eng_prob2;

    logic        busy4, done4, no_move4, eng_rst4;
    logic [1:0]  best_dir4, eng_dir4;
    logic [31:0] best_score4;
    logic [79:0] eng_board4;
    logic [2:0]  eng_prob4;

`ifdef MC_TIMEOUT_EN
    logic        to_seen2, to_seen4;
`endif

    always #5 clk = ~clk;

    mc_move_scheduler #(.TRIALS(2), .CNT_W(15), .SUM_W(15)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .board_in(board_in),
        .busy(busy2), .done(done2), .best_dir(best_dir2), .best_score(best_score2),
        .no_move(no_move2), .eng_rst(eng_rst2), .eng_board(eng_board2),
        .eng_dir(eng_dir2), .eng_prob(eng_prob2), .eng_done(eng_done),
        .eng_count(eng_count), .eng_illegal(eng_illegal)
`ifdef MC_TIMEOUT_EN
        , .timeout_seen(to_seen2)
`endif
    );

    mc_move_scheduler #(.TRIALS(4), .CNT_W(15), .SUM_W(32)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .board_in(board_in),
        .busy(busy4), .done(done4), .best_dir(best_dir4), .best_score(best_score4),
        .no_move(no_move4), .eng_rst(eng_rst4), .eng_board(eng_board4),
        .eng_dir(eng_dir4), .eng_prob(eng_prob4), .eng_done(eng_done),
        .eng_count(eng_count), .eng_illegal(eng_illegal)
`ifdef MC_TIMEOUT_EN
        , .timeout_seen(to_seen4)
`endif
    );

    logic        sel4;
    logic        sel_busy, sel_done, sel_no_move, sel_eng_rst;
    logic [1:0]  sel_best_dir, sel_eng_dir;
    logic [31:0] sel_score;

    assign sel_busy     = sel4 ? busy4 : busy2;
    assign sel_done     = sel4 ? done4 : done2;
    assign sel_no_move  = sel4 ? no_move4 : no_move2;
    assign sel_eng_rst  = sel4 ? eng_rst4 : eng_rst2;
    assign sel_best_dir = sel4 ? best_dir4 : best_dir2;
    assign sel_eng_dir  = sel4 ? eng_dir4 : eng_dir2;
    assign sel_score    = sel4 ? best_score4 : {17'd0, best_score2};

    int          compared = 0;
    int          mismatched = 0;
    int          launches;
    int          res_cyc;
    bit          got_done;
    logic [1:0]  dir_log [16];
    logic [14:0] resp_count [16];
    logic        resp_illegal [16];
    logic [1:0]  res_dir;
    logic [31:0] res_score;
    logic        res_nomove, res_busy;

    localparam logic [79:0] BOARD_A = 80'h1234_5678_9ABC_DEF0_1357;

    task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_resp();
        for (int i = 0; i < 16; i++) begin
            resp_count[i]   = '0;
            resp_illegal[i] = 1'b0;
            dir_log[i]      = '0;
        end
    endtask

    task automatic set_resp(input int idx, input logic [14:0] cnt, input logic ill);
        resp_count[idx]   = cnt;
        resp_illegal[idx] = ill;
    endtask

    // Called on a negedge; returns on the negedge of the first LAUNCH cycle.
    task automatic start_run(input bit use4);
        sel4 = use4;
        if (use4) start4 = 1'b1; else start2 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        start2 = 1'b0;
    endtask

    // Scripted engine: answers each launch one WAIT cycle later with the next table entry.
    task automatic run_eval(input int budget);
        int cyc;
        bit fin;
        launches = 0;
        got_done = 1'b0;
        cyc      = 0;
        fin      = 1'b0;
        while (!fin && cyc < budget) begin
            if (sel_done) begin
                got_done   = 1'b1;
                res_dir    = sel_best_dir;
                res_score  = sel_score;
                res_nomove = sel_no_move;
                res_busy   = sel_busy;
                res_cyc    = cyc;
                fin        = 1'b1;
            end else if (sel_eng_rst) begin
                if (launches < 16) dir_log[launches] = sel_eng_dir;
                @(negedge clk); cyc++;
                eng_done    = 1'b1;
                eng_count   = (launches < 16) ? resp_count[launches] : 15'd0;
                eng_illegal = (launches < 16) ? resp_illegal[launches] : 1'b0;
                launches++;
                @(negedge clk); cyc++;
                eng_done    = 1'b0;
                eng_count   = '0;
                eng_illegal = 1'b0;
            end else begin
                @(negedge clk); cyc++;
            end
        end
    endtask

    initial begin
        bit flag;
        rst = 1'b0; start2 = 1'b1; start4 = 1'b1; sel4 = 1'b0;
        board_in = '0; eng_done = 1'b0; eng_count = '0; eng_illegal = 1'b0;
        clear_resp();

        // Reset held with start high
        repeat (3) @(negedge clk);
        check_output("rst_eng_rst2", eng_rst2, 1);
        check_output("rst_eng_rst4", eng_rst4, 1);
        check_output("rst_busy2", busy2, 0);
        check_output("rst_busy4", busy4, 0);
        check_output("rst_done4", done4, 0);
        check_output("rst_prob4", eng_prob4, 0);
        check_output("rst_score4", best_score4, 0);
        start2 = 1'b0; start4 = 1'b0; rst = 1'b1;
        flag = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (eng_rst2 || eng_rst4 || busy2 || busy4) flag = 1'b1;
        end
        check_output("rst_no_launch", flag, 0);

        // Basic run, TRIALS=2
        $display("[TB] basic run");
        clear_resp();
        set_resp(0, 5, 0); set_resp(1, 5, 0); set_resp(2, 9, 0); set_resp(3, 1, 0);
        set_resp(4, 3, 0); set_resp(5, 3, 0); set_resp(6, 4, 0); set_resp(7, 4, 0);
        board_in = BOARD_A;
        start_run(1'b0);
        board_in = '0;
        check_output("basic_busy", busy2, 1);
        check_output("basic_prob", eng_prob2, 7);
        run_eval(500);
        check_output("basic_done", got_done, 1);
        check_output("basic_launches", launches, 8);
        check_output("basic_dir_log2", dir_log[2], 1);
        check_output("basic_dir_log7", dir_log[7], 3);
        check_output("basic_best_dir", res_dir, 0);
        check_output("basic_best_score", res_score, 10);
        check_output("basic_no_move", res_nomove, 0);
        check_output("basic_busy_at_done", res_busy, 0);
        check_output("basic_latency", res_cyc, 17);
        check_output("basic_board", eng_board2, BOARD_A);
        @(negedge clk);
        check_output("basic_done_pulse", done2, 0);
        check_output("basic_hold_score", best_score2, 10);

        // Busy start ignored, then abort by reset mid-WAIT
        $display("[TB] busy and abort");
        start_run(1'b1);
        check_output("abort_launch", eng_rst4, 1);
        @(negedge clk);
        eng_done = 1'b1; eng_count = 15'd100;
        @(negedge clk);
        eng_done = 1'b0; eng_count = '0;
        check_output("abort_second_launch", eng_rst4, 1);
        @(negedge clk);
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        check_output("abort_busy_kept", busy4, 1);
        check_output("abort_start_ignored", eng_rst4, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_output("abort_rst_busy", busy4, 0);
        check_output("abort_rst_eng_rst", eng_rst4, 1);
        rst = 1'b1;
        flag = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (done4 || eng_rst4 || busy4) flag = 1'b1;
        end
        check_output("abort_quiet", flag, 0);

        // Illegal skip, TRIALS=4; the ignored illegal count would otherwise win
        $display("[TB] illegal skip");
        clear_resp();
        for (int i = 0; i < 13; i++) set_resp(i, 2, 0);
        set_resp(4, 50, 1);
        start_run(1'b1);
        run_eval(500);
        check_output("skip_done", got_done, 1);
        check_output("skip_launches", launches, 13);
        check_output("skip_dir_log0", dir_log[0], 0);
        check_output("skip_dir_log4", dir_log[4], 1);
        check_output("skip_dir_log5", dir_log[5], 2);
        check_output("skip_best_dir", res_dir, 0);
        check_output("skip_best_score", res_score, 8);
        check_output("skip_no_move", res_nomove, 0);

        // Every direction illegal
        $display("[TB] all illegal");
        clear_resp();
        for (int i = 0; i < 16; i++) set_resp(i, 7, 1);
        @(negedge clk);
        start_run(1'b1);
        run_eval(500);
        check_output("allill_done", got_done, 1);
        check_output("allill_launches", launches, 4);
        check_output("allill_dir_log3", dir_log[3], 3);
        check_output("allill_no_move", res_nomove, 1);
        check_output("allill_best_dir", res_dir, 0);
        check_output("allill_best_score", res_score, 0);

        // Saturation on the 15-bit accumulator; dir2 saturates and must win
        $display("[TB] saturation");
        clear_resp();
        set_resp(0, 100, 0); set_resp(1, 100, 0); set_resp(2, 0, 1);
        set_resp(3, 30000, 0); set_resp(4, 5000, 0);
        set_resp(5, 20000, 0); set_resp(6, 10000, 0);
        @(negedge clk);
        start_run(1'b0);
        run_eval(500);
        check_output("sat_done", got_done, 1);
        check_output("sat_launches", launches, 7);
        check_output("sat_best_dir", res_dir, 2);
        check_output("sat_best_score", res_score, 32767);
        check_output("sat_no_move", res_nomove, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
